// File: rtl/instr_encoder.sv
// RV32 instruction word builder: validates format/opcode/immediate, then queues
// legal words in a 2-entry valid/ready FIFO and counts encoded/rejected requests.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] enc_count,
  output logic [7:0]       err_count
);

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2,
                         F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  enc_req_t    req;
  logic        op_ok, imm_ok, legal, accept, push, pop;
  logic [1:0]  code;
  logic [31:0] word;

  logic [1:0][31:0] mem;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       cnt;

  assign req = '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                 funct3: funct3, funct7: funct7, imm: imm};

  always_comb begin
    op_ok  = 1'b0;
    imm_ok = 1'b1;
    case (req.fmt)
      F_R: op_ok = req.opcode[6:2] inside {5'b01100, 5'b01011, 5'b01110, 5'b10100};
      F_I: op_ok = req.opcode[6:2] inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                           5'b00100, 5'b00110, 5'b00111, 5'b11001};
      F_S: op_ok = req.opcode[6:2] inside {5'b01000, 5'b01001};
      F_B: op_ok = req.opcode[6:2] == 5'b11000;
      F_U: op_ok = req.opcode[6:2] inside {5'b00101, 5'b01101};
      F_J: op_ok = req.opcode[6:2] == 5'b11011;
      default: op_ok = 1'b0;
    endcase
    op_ok = op_ok & (req.opcode[1:0] == 2'b11);

    case (req.fmt)
      F_I, F_S: imm_ok = (&req.imm[31:11]) | ~(|req.imm[31:11]);
      F_B:      imm_ok = ((&req.imm[31:12]) | ~(|req.imm[31:12])) & ~req.imm[0];
      F_J:      imm_ok = ((&req.imm[31:20]) | ~(|req.imm[31:20])) & ~req.imm[0];
      F_U:      imm_ok = ~(|req.imm[11:0]);
      default:  imm_ok = 1'b1;
    endcase

    // format beats opcode beats immediate
    if (req.fmt > F_J)  code = 2'b01;
    else if (!op_ok)    code = 2'b10;
    else if (!imm_ok)   code = 2'b11;
    else                code = 2'b00;
    legal = (code == 2'b00);
  end

  always_comb begin
    word = '0;
    case (req.fmt)
      F_R: word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      F_I: word = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      F_S: word = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
      F_B: word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                   req.imm[4:1], req.imm[11], req.opcode};
      F_U: word = {req.imm[31:12], req.rd, req.opcode};
      F_J: word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                   req.rd, req.opcode};
      default: word = '0;
    endcase
  end

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem       <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      cnt       <= 2'd0;
      err_valid <= 1'b0;
      err_code  <= 2'b00;
      enc_count <= '0;
      err_count <= 8'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= ~wr_ptr;
        enc_count   <= enc_count + 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      err_valid <= accept & ~legal;
      err_code  <= (accept & ~legal) ? code : 2'b00;
      if (accept && !legal && err_count != 8'd255)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected words/error codes,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  err_q[$];
  logic [15:0] exp_enc = '0;
  logic [7:0]  exp_err = '0;
  bit          hold = 0;
  logic [31:0] prev_instr = '0;

  instr_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_valid(err_valid), .err_code(err_code),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare the head on every handshake and every error pulse.
  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_instr", out_instr, prev_instr);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %h expected none", out_instr);
        end else begin
          chk("out_instr", out_instr, exp_q.pop_front());
        end
      end
      if (err_valid) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_err: got code %0d expected none", err_code);
        end else begin
          chk("err_code", {30'b0, err_code}, {30'b0, err_q.pop_front()});
        end
      end
      hold = out_valid && !out_ready;
      prev_instr = out_instr;
    end
  end

  // Presents a request and leaves in_valid high; returns 1ns after the accepting edge.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im,
                      input bit ok, input logic [31:0] expv);
    bit got = 0;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (ok) begin
      exp_q.push_back(expv);
      exp_enc++;
    end else begin
      err_q.push_back(expv[1:0]);
      if (exp_err != 8'd255) exp_err++;
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || err_q.size() != 0); i++)
      @(posedge clk);
    #1;
    chk("drain_words_left", exp_q.size(), 32'd0);
    chk("drain_errs_left", err_q.size(), 32'd0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_enc_count"}, {16'b0, enc_count}, {16'b0, exp_enc});
    chk({tag, "_err_count"}, {24'b0, err_count}, {24'b0, exp_err});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_err_valid", {31'b0, err_valid}, 32'd0);
    chk("rst_err_code", {30'b0, err_code}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk_counts("rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Legal single beats
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093);
    idle(); @(negedge clk);
    chk("lat_out_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 32'h002081B3);
    send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1, 32'h0020A423);
    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1, 32'hFE208EE3);
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 32'h001000EF);
    send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1, 32'h123452B7);
    idle();
    chk("six_enc_count", {16'b0, enc_count}, 32'd6);
    drain();

    // Error cases
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 32'd3);
    send(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 0, 32'd1);
    send(3'd1, 7'b0110011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 0, 32'd2);
    send(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 32'd1);
    idle();
    chk("err_no_write", {31'b0, out_valid}, 32'd0);
    chk("err_four", {24'b0, err_count}, 32'd4);
    chk_counts("errs");
    drain();

    // Backpressure: third request waits for a free slot
    out_ready = 1'b0;
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093);
    send(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500113);
    chk("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
    fork
      send(3'd1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500193);
      begin repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
    join
    idle();
    drain();

    // Full FIFO ignores even illegal requests
    out_ready = 1'b0;
    send(3'd1, 7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1, 32'h00700213);
    send(3'd1, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1, 32'h00700293);
    fmt = 3'd6; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_no_err", {31'b0, err_valid}, 32'd0);
      chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    end
    idle(); @(posedge clk); #1;
    chk_counts("full");
    drain();

    // Push and pop every cycle at occupancy 1
    for (int i = 0; i < 10; i++) begin
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, i, 1,
           (32'(i) << 20) | 32'h00000093);
      if (i > 0) begin
        chk("pp_in_ready", {31'b0, in_ready}, 32'd1);
        chk("pp_out_valid", {31'b0, out_valid}, 32'd1);
      end
    end
    idle();
    drain();

    // err_count saturation
    for (int i = 0; i < 300; i++)
      send(3'd6, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 0, 32'd1);
    idle();
    drain();
    chk("sat_err_count", {24'b0, err_count}, 32'd255);
    chk_counts("sat");

    // Asynchronous reset with two buffered words
    out_ready = 1'b0;
    send(3'd1, 7'b0010011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1, 32'h00100313);
    send(3'd1, 7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1, 32'h00100393);
    idle();
    #2 rst = 1'b1;
    exp_q.delete(); err_q.delete(); exp_enc = '0; exp_err = '0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out_instr", out_instr, 32'd0);
    chk("mid_rst_err_valid", {31'b0, err_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk_counts("mid_rst");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
